// File: rtl/jpeg_quant_zigzag_if.sv
// Coefficient stream bundle for jpeg_quant_zigzag: raster-order input beats and zigzag-order output beats.
// Table_Sel exists only when JPEG_QZ_CHROMA_EN is defined.
interface jpeg_quant_zigzag_if #(
    parameter int DATA_W = 12
) ();
    logic                     En_In;
    logic signed [DATA_W-1:0] In_Data;
`ifdef JPEG_QZ_CHROMA_EN
    logic                     Table_Sel;
`endif
    logic signed [DATA_W-1:0] Out_Data;
    logic                     En_Out;
    logic                     Out_Last;

`ifdef JPEG_QZ_CHROMA_EN
    modport master (output En_In, In_Data, Table_Sel, input Out_Data, En_Out, Out_Last);
    modport slave  (input En_In, In_Data, Table_Sel, output Out_Data, En_Out, Out_Last);
`else
    modport master (output En_In, In_Data, input Out_Data, En_Out, Out_Last);
    modport slave  (input En_In, In_Data, output Out_Data, En_Out, Out_Last);
`endif
endinterface

// File: rtl/jpeg_quant_zigzag.sv
// JPEG quantizer (reciprocal multiply, ties away from zero) with ping-pong zigzag reorder buffer.
// Optional chroma table selected by defining JPEG_QZ_CHROMA_EN.
module jpeg_quant_zigzag #(
    parameter int DATA_W = 12,
    parameter int FRAC_W = 16
) (
    input  logic                Clock,
    input  logic                Reset_n,
    jpeg_quant_zigzag_if.slave  bus
);
    localparam int PROD_W = DATA_W + FRAC_W + 1;
    localparam int MAG_W  = PROD_W - FRAC_W + 1;
    localparam logic [PROD_W:0]  RND     = (PROD_W+1)'(2**(FRAC_W-1));
    localparam logic [MAG_W-1:0] POS_LIM = MAG_W'(2**(DATA_W-1) - 1);
    localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(2**(DATA_W-1));

    localparam int LUMA_Q [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68,109,103, 77,   24, 35, 55, 64, 81,104,113, 92,
        49, 64, 78, 87,103,121,120,101,   72, 92, 95, 98,112,100,103, 99};

    localparam int ZZ [64] = '{
         0, 1, 8,16, 9, 2, 3,10,  17,24,32,25,18,11, 4, 5,
        12,19,26,33,40,48,41,34,  27,20,13, 6, 7,14,21,28,
        35,42,49,56,57,50,43,36,  29,22,15,23,30,37,44,51,
        58,59,52,45,38,31,39,46,  53,60,61,54,47,55,62,63};

    typedef enum logic {IDLE, READ} rd_state_e;

    // Reciprocal ROMs are folded to constants at elaboration; no divider is built.
    logic [FRAC_W:0] luma_recip [64];
    for (genvar g = 0; g < 64; g++) begin : g_luma
        assign luma_recip[g] = (FRAC_W+1)'((2**FRAC_W + LUMA_Q[g] / 2) / LUMA_Q[g]);
    end

    logic [5:0]               idx_q;
    logic                     s1_vld_q, s1_sign_q;
    logic [DATA_W-1:0]        s1_abs_q;
    logic [FRAC_W:0]          s1_recip_q;
    logic [5:0]               s1_idx_q;
    logic                     s2_vld_q;
    logic signed [DATA_W-1:0] s2_val_q;
    logic [5:0]               s2_idx_q;
    logic [DATA_W-1:0]        in_abs;
    logic [FRAC_W:0]          recip_sel;

    assign in_abs = bus.In_Data[DATA_W-1] ? $unsigned(-bus.In_Data) : $unsigned(bus.In_Data);

`ifdef JPEG_QZ_CHROMA_EN
    localparam int CHROMA_Q [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,   18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,   47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99};

    logic [FRAC_W:0] chroma_recip [64];
    for (genvar g = 0; g < 64; g++) begin : g_chroma
        assign chroma_recip[g] = (FRAC_W+1)'((2**FRAC_W + CHROMA_Q[g] / 2) / CHROMA_Q[g]);
    end

    logic tbl_q;
    logic tbl_sel;
    // The idx-0 beat uses its own Table_Sel directly; later beats use the value latched with it.
    assign tbl_sel   = (idx_q == 6'd0) ? bus.Table_Sel : tbl_q;
    assign recip_sel = tbl_sel ? chroma_recip[idx_q] : luma_recip[idx_q];

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)                              tbl_q <= 1'b0;
        else if (bus.En_In && idx_q == 6'd0)       tbl_q <= bus.Table_Sel;
    end
`else
    assign recip_sel = luma_recip[idx_q];
`endif

    // Stage 2 arithmetic: operands widened so the product and rounding add never overflow.
    logic [PROD_W:0]          prod, rnd_sum;
    logic [MAG_W-1:0]         mag;
    logic signed [DATA_W-1:0] q_val;

    assign prod    = {{(PROD_W+1-DATA_W){1'b0}}, s1_abs_q} * {{(PROD_W-FRAC_W){1'b0}}, s1_recip_q};
    assign rnd_sum = prod + RND;
    assign mag     = rnd_sum[PROD_W:FRAC_W];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        q_val = '0;
        if (s1_sign_q) begin
            if (mag > NEG_LIM) q_val = {1'b1, {(DATA_W-1){1'b0}}};
            else               q_val = $signed(-mag[DATA_W-1:0]);
        end else begin
            if (mag > POS_LIM) q_val = {1'b0, {(DATA_W-1){1'b1}}};
            else               q_val = $signed(mag[DATA_W-1:0]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_abs_q   <= '0;
            s1_recip_q <= '0;
            s1_idx_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_val_q   <= '0;
            s2_idx_q   <= '0;
        end else begin
            s1_vld_q <= bus.En_In;
            s2_vld_q <= s1_vld_q;
            if (bus.En_In) begin
                idx_q      <= idx_q + 6'd1;
                s1_sign_q  <= bus.In_Data[DATA_W-1];
                s1_abs_q   <= in_abs;
                s1_recip_q <= recip_sel;
                s1_idx_q   <= idx_q;
            end
            if (s1_vld_q) begin
                s2_val_q <= q_val;
                s2_idx_q <= s1_idx_q;
            end
        end
    end

    // Ping-pong storage: bank bit is the MSB of the address.
    logic signed [DATA_W-1:0] mem_q [128];
    logic                     wr_bank_q, wr_bank_d;
    logic                     blk_done;

    assign blk_done = s2_vld_q && (s2_idx_q == 6'd63);

    // NOTE: the buffer RAM has no reset; every location is written before it is read out.
    always_ff @(posedge Clock) begin
        if (s2_vld_q) mem_q[{wr_bank_q, s2_idx_q}] <= s2_val_q;
    end

    rd_state_e state_q, state_d;
    logic [5:0] rd_cnt_q, rd_cnt_d;
    logic       rd_bank_q, rd_bank_d;
    logic       pend_q, pend_d;

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        pend_d    = pend_q;
        wr_bank_d = blk_done ? ~wr_bank_q : wr_bank_q;
        case (state_q)
            IDLE: if (blk_done) begin
                state_d   = READ;
                rd_cnt_d  = '0;
                rd_bank_d = wr_bank_q;
            end
            READ: begin
                rd_cnt_d = rd_cnt_q + 6'd1;
                if (rd_cnt_q == 6'd63) begin
                    if (blk_done)    rd_bank_d = wr_bank_q;
                    else if (pend_q) begin
                        rd_bank_d = ~rd_bank_q;
                        pend_d    = 1'b0;
                    end else         state_d = IDLE;
                end else if (blk_done) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic signed [DATA_W-1:0] out_q;
    logic                     en_out_q, last_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            wr_bank_q <= 1'b0;
            pend_q    <= 1'b0;
            out_q     <= '0;
            en_out_q  <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
            wr_bank_q <= wr_bank_d;
            pend_q    <= pend_d;
            en_out_q  <= (state_q == READ);
            last_q    <= (state_q == READ) && (rd_cnt_q == 6'd63);
            if (state_q == READ) out_q <= mem_q[{rd_bank_q, 6'(ZZ[rd_cnt_q])}];
        end
    end

    assign bus.Out_Data = out_q;
    assign bus.En_Out   = en_out_q;
    assign bus.Out_Last = last_q;
endmodule

// File: tb/tb_jpeg_quant_zigzag.sv
// Directed and randomised-gap bench for jpeg_quant_zigzag with an independent quantize/zigzag model.
// Chroma cases run only when JPEG_QZ_CHROMA_EN is defined.
module tb_jpeg_quant_zigzag;
    typedef int blk_t [64];

    logic Clock = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clock = ~Clock;

    jpeg_quant_zigzag_if #(.DATA_W(12)) bus ();

    jpeg_quant_zigzag #(.DATA_W(12), .FRAC_W(16)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int out_pos = 0;
    int exp_q[$];
    int lastin_q[$];
    int first_q[$];
    int zz_tab [64];

    int q_luma [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68,109,103, 77,   24, 35, 55, 64, 81,104,113, 92,
        49, 64, 78, 87,103,121,120,101,   72, 92, 95, 98,112,100,103, 99};
    int q_chroma [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,   18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,   47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99};

    task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge Clock) cyc <= cyc + 1;

    // Zigzag order built by walking anti-diagonals, alternating direction.
    function automatic void build_zz();
        int p = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz_tab[p] = r * 8 + (s - r); p++; end
            else            for (int r = lo; r <= hi; r++) begin zz_tab[p] = r * 8 + (s - r); p++; end
        end
    endfunction

    function automatic int quant(input int x, input int q);
        longint recip = (65536 + q / 2) / q;
        longint a = (x < 0) ? -x : x;
        longint m = (a * recip + 32768) >>> 16;
        if (x < 0) begin
            if (m > 2048) m = 2048;
            return -int'(m);
        end
        if (m > 2047) m = 2047;
        return int'(m);
    endfunction

    function automatic blk_t model(input blk_t c, input bit tsel);
        blk_t e;
        for (int p = 0; p < 64; p++) begin
            int r = zz_tab[p];
            e[p] = quant(c[r], tsel ? q_chroma[r] : q_luma[r]);
        end
        return e;
    endfunction

    always @(negedge Clock) begin
        if (!Reset_n) begin
            out_pos = 0;
        end else if (bus.En_Out) begin
            if (exp_q.size() == 0) begin
                check("spurious_en_out", 1, 0);
            end else begin
                check("zz_data", bus.Out_Data, exp_q.pop_front());
                check("out_last", bus.Out_Last, (out_pos == 63) ? 1 : 0);
                if (out_pos == 0 && lastin_q.size() != 0) begin
                    check("first_out_latency", cyc - lastin_q.pop_front(), 4);
                    first_q.push_back(cyc);
                end
                out_pos = (out_pos + 1) % 64;
            end
        end else if (bus.Out_Last) begin
            check("last_without_en", 1, 0);
        end
    end

    task automatic send(input blk_t c, input blk_t e, input int n, input int gap_pct, input bit tsel);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                @(negedge Clock);
                bus.En_In = 1'b0;
            end
            @(negedge Clock);
            bus.En_In   = 1'b1;
            bus.In_Data = 12'(c[i]);
`ifdef JPEG_QZ_CHROMA_EN
            bus.Table_Sel = tsel;
`endif
            if (i == 63) begin
                for (int p = 0; p < 64; p++) exp_q.push_back(e[p]);
                lastin_q.push_back(cyc);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clock);
            bus.En_In = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 400; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge Clock);
        end
        check("drain_outstanding", exp_q.size(), 0);
        exp_q.delete();
        lastin_q.delete();
        idle(3);
    endtask

    function automatic blk_t rand_blk(input int span);
        blk_t c;
        for (int i = 0; i < 64; i++) c[i] = int'($urandom_range(2 * span)) - span;
        return c;
    endfunction

    initial begin
        blk_t c, e, zero;
        zero = '{default: 0};
        build_zz();
        bus.En_In   = 1'b0;
        bus.In_Data = '0;
`ifdef JPEG_QZ_CHROMA_EN
        bus.Table_Sel = 1'b0;
`endif
        repeat (3) @(negedge Clock);
        check("rst_out_data", bus.Out_Data, 0);
        check("rst_en_out", bus.En_Out, 0);
        check("rst_out_last", bus.Out_Last, 0);
        Reset_n = 1'b1;
        idle(2);

        // DC-only block: 800/16 -> 50 at zigzag position 0
        c = zero; c[0] = 800; e = zero; e[0] = 50;
        send(c, e, 64, 0, 1'b0); idle(1); wait_drain();

        // +/-1.5 ties round away from zero
        c = zero; c[0] = -24; e = zero; e[0] = -2;
        send(c, e, 64, 0, 1'b0);
        c = zero; c[0] = 24; e = zero; e[0] = 2;
        send(c, e, 64, 0, 1'b0); idle(1); wait_drain();

        // raster 8 -> zigzag 2, raster 1 -> zigzag 1
        c = zero; c[8] = 120; c[1] = -55; e = zero; e[2] = 10; e[1] = -5;
        send(c, e, 64, 0, 1'b0); idle(1); wait_drain();

        // Back-to-back blocks: continuous 128-beat output across the bank swap
        first_q.delete();
        c = rand_blk(600); send(c, model(c, 1'b0), 64, 0, 1'b0);
        c = rand_blk(600); send(c, model(c, 1'b0), 64, 0, 1'b0);
        idle(1); wait_drain();
        if (first_q.size() == 2) check("b2b_first_spacing", first_q[1] - first_q[0], 64);
        else                     check("b2b_block_count", first_q.size(), 2);

        // Random gaps with full-scale inputs
        for (int b = 0; b < 3; b++) begin
            c = rand_blk(2047);
            c[0] = -2048; c[1] = 2047; c[8] = -2048; c[63] = 2047;
            send(c, model(c, 1'b0), 64, 50, 1'b0);
        end
        idle(1); wait_drain();

        // Reset after a partial block: nothing emitted, next beat is idx 0
        c = rand_blk(1000);
        send(c, zero, 30, 0, 1'b0);
        @(negedge Clock);
        bus.En_In = 1'b0;
        Reset_n   = 1'b0;
        @(negedge Clock);
        check("midrst_en_out", bus.En_Out, 0);
        check("midrst_out_data", bus.Out_Data, 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        idle(2);
        c = rand_blk(1500); c[0] = 1000;
        send(c, model(c, 1'b0), 64, 25, 1'b0); idle(1); wait_drain();

`ifdef JPEG_QZ_CHROMA_EN
        c = zero; c[0] = 170; e = zero; e[0] = 10;
        send(c, e, 64, 0, 1'b1); idle(1); wait_drain();
        c = rand_blk(2047);
        send(c, model(c, 1'b1), 64, 30, 1'b1); idle(1); wait_drain();
`endif

        idle(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
